// File: rtl/neuron_param_loader_pkg.sv
// Shared types and constants for the neuron parameter loader.
//   loader_state_t : FSM encoding (IDLE, WEIGHT, BIAS, DONE)
//   BUS_WIDTH      : width of the parameter stream and broadcast bus
package nn_loader_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WEIGHT = 2'd1,
        BIAS   = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/neuron_param_loader_if.sv
// Ready/valid parameter stream feeding the neuron parameter loader.
//   s_data  : parameter word (weight or bias)
//   s_valid : s_data valid
//   s_ready : loader consumes s_data this cycle
// master modport = host/DMA side, slave modport = loader side.
interface neuron_param_loader_if;
    import nn_loader_pkg::*;

    logic [BUS_WIDTH-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/neuron_param_loader.sv
// Loads NUM_WEIGHT weights followed by one bias into the neuron selected by
// (layer, neuron), driving the broadcast parameter bus shared by a layer.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   start, cfg_layer, cfg_neuron    load command and target (IDLE only)
//   s (slave)                       ready/valid parameter word stream
//   mWeight/mWeightValid            registered weight word + 1-cycle pulse
//   mBias/mBiasValid                registered bias word + 1-cycle pulse
//   config_layer_num/neuron_num     target latched at the accepted start
//   busy, done, start_err           status: not idle, load done, start dropped
module neuron_param_loader
    import nn_loader_pkg::*;
#(
    parameter int NUM_WEIGHT = 784,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(NUM_WEIGHT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] cfg_layer,
    input  logic [BUS_WIDTH-1:0] cfg_neuron,
    neuron_param_loader_if.slave s,
    output logic [BUS_WIDTH-1:0] mWeight,
    output logic                 mWeightValid,
    output logic [BUS_WIDTH-1:0] mBias,
    output logic                 mBiasValid,
    output logic [BUS_WIDTH-1:0] config_layer_num,
    output logic [BUS_WIDTH-1:0] config_neuron_num,
    output logic                 busy,
    output logic                 done,
    output logic                 start_err
);

    // Keep the counter at least one bit wide so degenerate sizes still elaborate.
    localparam int CW = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WEIGHT - 1);

    // The neuron value lives in the low DATA_WIDTH bits of a bus word.
    if (DATA_WIDTH > BUS_WIDTH) begin : g_width_check
        $error("DATA_WIDTH must not exceed BUS_WIDTH");
    end
    if (NUM_WEIGHT < 1) begin : g_count_check
        $error("NUM_WEIGHT must be at least 1");
    end

    loader_state_t state_reg;
    logic [CW-1:0] wcnt_reg;
    logic          accept;

    assign s.s_ready = (state_reg == WEIGHT) || (state_reg == BIAS);
    assign accept    = s.s_valid && s.s_ready;
    assign busy      = (state_reg != IDLE);
    // DONE lasts exactly one cycle, so it doubles as the done pulse.
    assign done      = (state_reg == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg         <= IDLE;
            wcnt_reg          <= '0;
            mWeight           <= '0;
            mWeightValid      <= 1'b0;
            mBias             <= '0;
            mBiasValid        <= 1'b0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            start_err         <= 1'b0;
        end else begin
            mWeightValid <= 1'b0;
            mBiasValid   <= 1'b0;
            // A start outside IDLE (DONE included) is dropped and flagged.
            start_err    <= start && (state_reg != IDLE);

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg         <= WEIGHT;
                        config_layer_num  <= cfg_layer;
                        config_neuron_num <= cfg_neuron;
                        wcnt_reg          <= '0;
                    end
                end
                WEIGHT: begin
                    if (accept) begin
                        mWeight      <= s.s_data;
                        mWeightValid <= 1'b1;
                        // Every neuron advances on each weight pulse, so the
                        // count must be exact before moving on to the bias.
                        if (wcnt_reg == LAST_IDX) begin
                            wcnt_reg  <= '0;
                            state_reg <= BIAS;
                        end else begin
                            wcnt_reg <= wcnt_reg + CW'(1);
                        end
                    end
                end
                BIAS: begin
                    if (accept) begin
                        mBias      <= s.s_data;
                        mBiasValid <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_param_loader.sv
// Scoreboard bench for neuron_param_loader with NUM_WEIGHT=4.
// The driver pushes the expected pulse (kind, value, cycle, target) for each
// accepted word; an independent monitor pops and checks every pulse.
module tb_neuron_param_loader;
    import nn_loader_pkg::*;

    localparam int NW = 4;

    typedef struct {
        bit          is_bias;
        logic [31:0] data;
        int          cyc;
        logic [31:0] layer;
        logic [31:0] neuron;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_layer = '0;
    logic [31:0] cfg_neuron = '0;
    logic [31:0] mWeight, mBias, config_layer_num, config_neuron_num;
    logic        mWeightValid, mBiasValid, busy, done, start_err;

    neuron_param_loader_if lif ();

    neuron_param_loader #(.NUM_WEIGHT(NW), .DATA_WIDTH(16)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .cfg_layer         (cfg_layer),
        .cfg_neuron        (cfg_neuron),
        .s                 (lif),
        .mWeight           (mWeight),
        .mWeightValid      (mWeightValid),
        .mBias             (mBias),
        .mBiasValid        (mBiasValid),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .busy              (busy),
        .done              (done),
        .start_err         (start_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          w_tot = 0, b_tot = 0, d_tot = 0;
    int          w0, b0, d0;
    exp_t        q[$];
    logic [31:0] exp_layer = '0, exp_neuron = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (mWeightValid) w_tot++;
            if (mBiasValid) b_tot++;
            if (done) d_tot++;
            if (mWeightValid || mBiasValid) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {mWeightValid, mBiasValid}, 2'b00);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", {mWeightValid, mBiasValid}, e.is_bias ? 2'b01 : 2'b10);
                    check("pulse_data", e.is_bias ? mBias : mWeight, e.data);
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_layer", config_layer_num, e.layer);
                    check("pulse_neuron", config_neuron_num, e.neuron);
                    if (e.is_bias) check("done_with_bias", {31'b0, done}, 1);
                    $display("pulse %s data=%h cyc=%0d", e.is_bias ? "bias" : "weight",
                             e.is_bias ? mBias : mWeight, cyc);
                end
            end else if (done) begin
                check("stray_done", {31'b0, done}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] l, input logic [31:0] n);
        cfg_layer  = l;
        cfg_neuron = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        exp_layer  = l;
        exp_neuron = n;
        check("start_busy", {31'b0, busy}, 1);
        check("start_ready", {31'b0, lif.s_ready}, 1);
        check("start_cfg_layer", config_layer_num, l);
        check("start_cfg_neuron", config_neuron_num, n);
    endtask

    // Presents a word and waits (bounded) for it to be accepted; s_valid is
    // left high so consecutive calls stream without bubbles.
    task automatic send_word(input logic [31:0] d, input bit is_bias);
        bit   got = 0;
        exp_t e;
        lif.s_valid = 1'b1;
        lif.s_data  = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (lif.s_ready) begin
                e.is_bias = is_bias;
                e.data    = d;
                e.cyc     = cyc + 1;
                e.layer   = exp_layer;
                e.neuron  = exp_neuron;
                q.push_back(e);
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic snap();
        w0 = w_tot;
        b0 = b_tot;
        d0 = d_tot;
    endtask

    task automatic end_load(input string tag);
        int i = 0;
        lif.s_valid = 1'b0;
        while (busy && i < 50) begin
            tick();
            i++;
        end
        check({tag, "_idle"}, {31'b0, busy}, 0);
        check({tag, "_weights"}, w_tot - w0, NW);
        check({tag, "_bias"}, b_tot - b0, 1);
        check({tag, "_done"}, d_tot - d0, 1);
        check({tag, "_queue_empty"}, q.size(), 0);
        $display("load %s complete: weights=%0d bias=%0d", tag, w_tot - w0, b_tot - b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] basic_w [NW] = '{32'h0001, 32'h0002, 32'hFFFF, 32'h8000};
        logic [31:0] wide_w  [NW] = '{32'hA5A50001, 32'hDEAD8000, 32'h0000FFFF, 32'hFFFFFFFF};

        lif.s_valid = 1'b0;
        lif.s_data  = '0;

        // Reset values
        #2;
        check("rst_outputs", {31'b0, |{mWeight, mWeightValid, mBias, mBiasValid,
                                        config_layer_num, config_neuron_num,
                                        busy, done, start_err, lif.s_ready}}, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        check("post_rst_busy", {31'b0, busy}, 0);

        // Basic load, continuous valid
        snap();
        do_start(1, 2);
        for (int i = 0; i < NW; i++) send_word(basic_w[i], 0);
        send_word(32'h0010, 1);
        check("basic_done_now", {31'b0, done}, 1);
        check("basic_ready_in_done", {31'b0, lif.s_ready}, 0);
        end_load("basic");
        check("basic_cfg_hold_l", config_layer_num, 1);
        check("basic_cfg_hold_n", config_neuron_num, 2);

        // Stalls: valid drops on alternate cycles
        snap();
        do_start(1, 2);
        for (int i = 0; i < NW; i++) begin
            send_word(basic_w[i], 0);
            lif.s_valid = 1'b0;
            tick();
        end
        send_word(32'h0010, 1);
        end_load("stall");

        // Start while busy: in WEIGHT, BIAS and DONE
        snap();
        do_start(1, 2);
        for (int i = 0; i < NW; i++) begin
            send_word(basic_w[i], 0);
            if (i == 1 || i == NW - 1) begin
                lif.s_valid = 1'b0;
                cfg_layer = 9; cfg_neuron = 9; start = 1'b1;
                tick();
                start = 1'b0;
                check("serr_pulse", {31'b0, start_err}, 1);
                check("serr_busy", {31'b0, busy}, 1);
                check("serr_cfg_l", config_layer_num, 1);
                check("serr_cfg_n", config_neuron_num, 2);
                tick();
                check("serr_one_cycle", {31'b0, start_err}, 0);
            end
        end
        send_word(32'h0010, 1);
        lif.s_valid = 1'b0;
        cfg_layer = 9; cfg_neuron = 9; start = 1'b1;
        tick();
        start = 1'b0;
        check("serr_done_pulse", {31'b0, start_err}, 1);
        check("serr_done_idle", {31'b0, busy}, 0);
        check("serr_done_cfg_n", config_neuron_num, 2);
        end_load("startbusy");

        // Idle data is not consumed; it becomes the first weight after start
        snap();
        lif.s_valid = 1'b1;
        lif.s_data  = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", {31'b0, lif.s_ready}, 0);
        end
        do_start(4, 5);
        send_word(32'h1234, 0);
        for (int i = 1; i < NW; i++) send_word(basic_w[i], 0);
        send_word(32'h0020, 1);
        end_load("idledata");

        // Back-to-back loads: second start at m+2
        snap();
        do_start(2, 0);
        for (int i = 0; i < NW; i++) send_word(wide_w[i], 0);
        send_word(32'hCAFE0010, 1);
        lif.s_valid = 1'b0;
        check("b2b_done", {31'b0, done}, 1);
        tick();
        check("b2b_idle_m2", {31'b0, busy}, 0);
        check("b2b_w1", w_tot - w0, NW);
        check("b2b_b1", b_tot - b0, 1);
        snap();
        do_start(2, 3);
        check("b2b_no_err", {31'b0, start_err}, 0);
        for (int i = 0; i < NW; i++) send_word(basic_w[NW - 1 - i], 0);
        send_word(32'h7FFF, 1);
        end_load("b2b");

        // Reset mid-load after two weights
        do_start(6, 7);
        send_word(32'h0101, 0);
        send_word(32'h0202, 0);
        lif.s_valid = 1'b0;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("midrst_outputs", {31'b0, |{mWeight, mWeightValid, mBias, mBiasValid,
                                           config_layer_num, config_neuron_num,
                                           busy, done, start_err, lif.s_ready}}, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("midrst_queue", q.size(), 0);
        tick();
        check("midrst_idle", {31'b0, busy}, 0);
        check("midrst_no_pulse", {30'b0, mWeightValid, mBiasValid}, 0);
        snap();
        do_start(8, 1);
        for (int i = 0; i < NW; i++) send_word(wide_w[i], 0);
        send_word(32'h0000ABCD, 1);
        end_load("afterrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
